// File: rtl/vlsu_axi_ot_limiter.sv
// Outstanding-burst limiter and drain gate between the VLSU AXI master port and the interconnect.
// Optional stall-cycle counters are built when VLSU_OT_LIMITER_STATS_EN is defined.
module vlsu_axi_ot_limiter #(
  parameter int unsigned MaxOutstandingReads  = 8,
  parameter int unsigned MaxOutstandingWrites = 8,
  parameter type axi_req_t = struct packed {
    struct packed {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
    } aw;
    logic aw_valid;
    struct packed {
      logic [31:0] data;
      logic [3:0]  strb;
      logic        last;
    } w;
    logic w_valid;
    logic b_ready;
    struct packed {
      logic [3:0]  id;
      logic [31:0] addr;
      logic [7:0]  len;
    } ar;
    logic ar_valid;
    logic r_ready;
  },
  parameter type axi_resp_t = struct packed {
    logic aw_ready;
    logic ar_ready;
    logic w_ready;
    logic b_valid;
    struct packed {
      logic [3:0] id;
      logic [1:0] resp;
    } b;
    logic r_valid;
    struct packed {
      logic [3:0]  id;
      logic [31:0] data;
      logic [1:0]  resp;
      logic        last;
    } r;
  },
  localparam int unsigned RdCntWidth = $clog2(MaxOutstandingReads + 1),
  localparam int unsigned WrCntWidth = $clog2(MaxOutstandingWrites + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  axi_req_t              slv_req_i,
  output axi_resp_t             slv_resp_o,
  output axi_req_t              mst_req_o,
  input  axi_resp_t             mst_resp_i,
  input  logic                  drain_req_i,
  output logic                  drain_ack_o,
  output logic [RdCntWidth-1:0] rd_outstanding_o,
  output logic [WrCntWidth-1:0] wr_outstanding_o,
  output logic                  error_o
`ifdef VLSU_OT_LIMITER_STATS_EN
  ,
  output logic [31:0]           rd_stall_cycles_o,
  output logic [31:0]           wr_stall_cycles_o
`endif
);

  localparam logic [1:0] StRun     = 2'd0;
  localparam logic [1:0] StDrain   = 2'd1;
  localparam logic [1:0] StDrained = 2'd2;

  localparam logic [RdCntWidth-1:0] RdMax = RdCntWidth'(MaxOutstandingReads);
  localparam logic [WrCntWidth-1:0] WrMax = WrCntWidth'(MaxOutstandingWrites);

  logic [1:0]            r_state, w_state_nxt;
  logic [RdCntWidth-1:0] r_rd_cnt, w_rd_cnt_nxt;
  logic [WrCntWidth-1:0] r_wr_cnt, w_wr_cnt_nxt;
  logic                  r_error, w_error_nxt;
  logic                  r_drain_ack;

  logic w_ar_block, w_aw_block;
  logic w_ar_hs, w_aw_hs, w_r_hs, w_r_last_hs, w_b_hs;
  logic w_rd_underflow, w_wr_underflow;

  // Blocking depends only on registered state: no ready->valid combinational path.
  assign w_ar_block = (r_rd_cnt == RdMax) || (r_state != StRun);
  assign w_aw_block = (r_wr_cnt == WrMax) || (r_state != StRun);

  always_comb begin
    mst_req_o          = slv_req_i;
    mst_req_o.ar_valid = slv_req_i.ar_valid && !w_ar_block;
    mst_req_o.aw_valid = slv_req_i.aw_valid && !w_aw_block;
  end

  always_comb begin
    slv_resp_o          = mst_resp_i;
    slv_resp_o.ar_ready = mst_resp_i.ar_ready && !w_ar_block;
    slv_resp_o.aw_ready = mst_resp_i.aw_ready && !w_aw_block;
  end

  assign w_ar_hs     = slv_req_i.ar_valid && !w_ar_block && mst_resp_i.ar_ready;
  assign w_aw_hs     = slv_req_i.aw_valid && !w_aw_block && mst_resp_i.aw_ready;
  assign w_r_hs      = mst_resp_i.r_valid && slv_req_i.r_ready;
  assign w_r_last_hs = w_r_hs && mst_resp_i.r.last;
  assign w_b_hs      = mst_resp_i.b_valid && slv_req_i.b_ready;

  always_comb begin
    w_rd_cnt_nxt   = r_rd_cnt;
    w_rd_underflow = 1'b0;
    if (w_ar_hs && !w_r_last_hs) begin
      w_rd_cnt_nxt = r_rd_cnt + RdCntWidth'(1);
    end else if (!w_ar_hs && w_r_last_hs) begin
      if (r_rd_cnt == '0) begin
        w_rd_underflow = 1'b1;
      end else begin
        w_rd_cnt_nxt = r_rd_cnt - RdCntWidth'(1);
      end
    end
  end

  always_comb begin
    w_wr_cnt_nxt   = r_wr_cnt;
    w_wr_underflow = 1'b0;
    if (w_aw_hs && !w_b_hs) begin
      w_wr_cnt_nxt = r_wr_cnt + WrCntWidth'(1);
    end else if (!w_aw_hs && w_b_hs) begin
      if (r_wr_cnt == '0) begin
        w_wr_underflow = 1'b1;
      end else begin
        w_wr_cnt_nxt = r_wr_cnt - WrCntWidth'(1);
      end
    end
  end

  // resp[1] covers both SLVERR and DECERR.
  assign w_error_nxt = r_error || w_rd_underflow || w_wr_underflow ||
                       (w_r_hs && mst_resp_i.r.resp[1]) ||
                       (w_b_hs && mst_resp_i.b.resp[1]);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      StRun: begin
        if (drain_req_i) w_state_nxt = StDrain;
      end
      StDrain: begin
        if (!drain_req_i) begin
          w_state_nxt = StRun;
        end else if ((r_rd_cnt == '0) && (r_wr_cnt == '0)) begin
          w_state_nxt = StDrained;
        end
      end
      StDrained: begin
        if (!drain_req_i) w_state_nxt = StRun;
      end
      default: w_state_nxt = StRun;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state     <= StRun;
      r_rd_cnt    <= '0;
      r_wr_cnt    <= '0;
      r_error     <= 1'b0;
      r_drain_ack <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_rd_cnt    <= w_rd_cnt_nxt;
      r_wr_cnt    <= w_wr_cnt_nxt;
      r_error     <= w_error_nxt;
      r_drain_ack <= (w_state_nxt == StDrained);
    end
  end

  assign drain_ack_o      = r_drain_ack;
  assign rd_outstanding_o = r_rd_cnt;
  assign wr_outstanding_o = r_wr_cnt;
  assign error_o          = r_error;

`ifdef VLSU_OT_LIMITER_STATS_EN
  logic [31:0] r_rd_stall, r_wr_stall;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_rd_stall <= '0;
      r_wr_stall <= '0;
    end else begin
      if (slv_req_i.ar_valid && w_ar_block && (r_rd_stall != '1)) begin
        r_rd_stall <= r_rd_stall + 32'd1;
      end
      if (slv_req_i.aw_valid && w_aw_block && (r_wr_stall != '1)) begin
        r_wr_stall <= r_wr_stall + 32'd1;
      end
    end
  end

  assign rd_stall_cycles_o = r_rd_stall;
  assign wr_stall_cycles_o = r_wr_stall;
`endif

endmodule

// File: tb/tb_vlsu_axi_ot_limiter.sv
// Self-checking bench for vlsu_axi_ot_limiter: vector table, directed corner cases and a
// randomized run against a counting reference model.
module tb_vlsu_axi_ot_limiter;

  localparam int MaxR = 2;
  localparam int MaxW = 4;
  localparam int RdW  = $clog2(MaxR + 1);
  localparam int WrW  = $clog2(MaxW + 1);

  typedef struct packed { logic [3:0] id; logic [31:0] addr; logic [7:0] len; } ax_t;
  typedef struct packed { logic [31:0] data; logic [3:0] strb; logic last; } w_t;
  typedef struct packed { logic [3:0] id; logic [1:0] resp; } b_t;
  typedef struct packed { logic [3:0] id; logic [31:0] data; logic [1:0] resp; logic last; } r_t;
  typedef struct packed {
    ax_t aw; logic aw_valid; w_t w; logic w_valid; logic b_ready;
    ax_t ar; logic ar_valid; logic r_ready;
  } req_t;
  typedef struct packed {
    logic aw_ready; logic ar_ready; logic w_ready; logic b_valid; b_t b;
    logic r_valid; r_t r;
  } resp_t;

  typedef struct packed {
    logic drain, ar_v, ar_rdy, r_v, r_last;
    logic [1:0] r_resp;
    logic aw_v, aw_rdy, b_v;
    logic [1:0] b_resp;
    logic e_mar_v, e_sar_rdy, e_maw_v;
    logic [RdW-1:0] e_rd;
    logic [WrW-1:0] e_wr;
    logic e_err, e_ack;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  req_t slv_req, mst_req;
  resp_t slv_resp, mst_resp;
  logic drain, drain_ack, err;
  logic [RdW-1:0] rd_out;
  logic [WrW-1:0] wr_out;
`ifdef VLSU_OT_LIMITER_STATS_EN
  logic [31:0] rd_stall, wr_stall;
`endif

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  vlsu_axi_ot_limiter #(
    .MaxOutstandingReads (MaxR),
    .MaxOutstandingWrites(MaxW),
    .axi_req_t           (req_t),
    .axi_resp_t          (resp_t)
  ) u_dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .slv_req_i       (slv_req),
    .slv_resp_o      (slv_resp),
    .mst_req_o       (mst_req),
    .mst_resp_i      (mst_resp),
    .drain_req_i     (drain),
    .drain_ack_o     (drain_ack),
    .rd_outstanding_o(rd_out),
    .wr_outstanding_o(wr_out),
    .error_o         (err)
`ifdef VLSU_OT_LIMITER_STATS_EN
    ,
    .rd_stall_cycles_o(rd_stall),
    .wr_stall_cycles_o(wr_stall)
`endif
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic vec_t mk(input int d, av, ard, rv, rl, rr, wv, wrd, bv, br,
                              input int mav, sar, maw, erd, ewr, eer, eak);
    vec_t v;
    v.drain = 1'(d);      v.ar_v = 1'(av);     v.ar_rdy = 1'(ard);
    v.r_v = 1'(rv);       v.r_last = 1'(rl);   v.r_resp = 2'(rr);
    v.aw_v = 1'(wv);      v.aw_rdy = 1'(wrd);  v.b_v = 1'(bv);   v.b_resp = 2'(br);
    v.e_mar_v = 1'(mav);  v.e_sar_rdy = 1'(sar); v.e_maw_v = 1'(maw);
    v.e_rd = RdW'(erd);   v.e_wr = WrW'(ewr);  v.e_err = 1'(eer); v.e_ack = 1'(eak);
    return v;
  endfunction

  task automatic idle();
    slv_req = '0;
    mst_resp = '0;
    slv_req.r_ready = 1'b1;
    slv_req.b_ready = 1'b1;
    drain = 1'b0;
  endtask

  // Called at posedge+1; returns at the next posedge+1 with the DUT out of reset.
  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic apply_row(input vec_t v, input int idx);
    string s;
    drain = v.drain;
    slv_req.ar_valid = v.ar_v;     mst_resp.ar_ready = v.ar_rdy;
    mst_resp.r_valid = v.r_v;      mst_resp.r.last = v.r_last;  mst_resp.r.resp = v.r_resp;
    slv_req.aw_valid = v.aw_v;     mst_resp.aw_ready = v.aw_rdy;
    mst_resp.b_valid = v.b_v;      mst_resp.b.resp = v.b_resp;
    #2;
    s = $sformatf("row%0d", idx);
    chk({s, "_mst_ar_valid"}, mst_req.ar_valid, v.e_mar_v);
    chk({s, "_slv_ar_ready"}, slv_resp.ar_ready, v.e_sar_rdy);
    chk({s, "_mst_aw_valid"}, mst_req.aw_valid, v.e_maw_v);
    @(posedge clk);
    #1;
    chk({s, "_rd_out"}, rd_out, v.e_rd);
    chk({s, "_wr_out"}, wr_out, v.e_wr);
    chk({s, "_error"}, err, v.e_err);
    chk({s, "_drain_ack"}, drain_ack, v.e_ack);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vec_t vq[$];
    int m_rd, m_wr, m_mode, m_rs, m_ws;
    bit m_err;

    idle();
    #12;
    rst_n = 1'b1;
    tick();
    chk("reset_rd_out", rd_out, 0);
    chk("reset_wr_out", wr_out, 0);
    chk("reset_error", err, 0);
    chk("reset_drain_ack", drain_ack, 0);

    // d av ard rv rl rr wv wrd bv br | mav sar maw rd wr err ack
    vq.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 2, 0, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 2, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 3, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 3, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 3, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 2, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vq.push_back(mk(1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 1, 0, 1, 0, 0));
    vq.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0));
    vq.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0));
    vq.push_back(mk(0, 0, 1, 1, 1, 2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    vq.push_back(mk(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 1, 0));
    vq.push_back(mk(0, 0, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0));
    foreach (vq[i]) apply_row(vq[i], i);

    // Error is sticky until reset; payloads pass straight through.
    do_reset();
    chk("err_cleared_by_reset", err, 0);
    slv_req.ar.addr = $urandom;
    slv_req.aw.addr = $urandom;
    slv_req.w.data = $urandom;
    mst_resp.r.data = $urandom;
    mst_resp.b.id = 4'(7);
    mst_resp.w_ready = 1'b1;
    slv_req.w_valid = 1'b1;
    #2;
    chk("pass_ar_addr", mst_req.ar.addr, slv_req.ar.addr);
    chk("pass_aw_addr", mst_req.aw.addr, slv_req.aw.addr);
    chk("pass_w_data", mst_req.w.data, slv_req.w.data);
    chk("pass_w_valid", mst_req.w_valid, 1);
    chk("pass_w_ready", slv_resp.w_ready, 1);
    chk("pass_r_data", slv_resp.r.data, mst_resp.r.data);
    chk("pass_b_id", slv_resp.b.id, 7);
    tick();

    // B with nothing outstanding.
    idle();
    mst_resp.b_valid = 1'b1;
    #2;
    chk("b_underflow_fwd", slv_resp.b_valid, 1);
    tick();
    mst_resp.b_valid = 1'b0;
    chk("b_underflow_wr", wr_out, 0);
    chk("b_underflow_err", err, 1);

    // Asynchronous reset mid-burst, then the stale R last arrives.
    do_reset();
    slv_req.ar_valid = 1'b1;
    mst_resp.ar_ready = 1'b1;
    tick();
    slv_req.ar_valid = 1'b0;
    chk("midrst_rd_before", rd_out, 1);
    rst_n = 1'b0;
    #1;
    chk("midrst_rd_async", rd_out, 0);
    #1;
    rst_n = 1'b1;
    tick();
    mst_resp.r_valid = 1'b1;
    mst_resp.r.last = 1'b1;
    tick();
    mst_resp.r_valid = 1'b0;
    chk("midrst_rd_after", rd_out, 0);
    chk("midrst_err", err, 1);

    // Drain from idle: ack lands two edges after the request.
    do_reset();
    drain = 1'b1;
    tick();
    chk("idle_drain_ack1", drain_ack, 0);
    tick();
    chk("idle_drain_ack2", drain_ack, 1);
    drain = 1'b0;
    tick();
    chk("idle_drain_release", drain_ack, 0);

`ifdef VLSU_OT_LIMITER_STATS_EN
    do_reset();
    slv_req.ar_valid = 1'b1;
    mst_resp.ar_ready = 1'b1;
    for (int i = 0; i < MaxR + 5; i++) tick();
    chk("stats_rd_stall", rd_stall, 5);
    chk("stats_wr_stall", wr_stall, 0);
`endif

    // Randomized run against a counting model.
    do_reset();
    m_rd = 0; m_wr = 0; m_mode = 0; m_err = 0; m_rs = 0; m_ws = 0;
    for (int c = 0; c < 600; c++) begin
      bit late, blk_r, blk_w, ar_hs, aw_hs, r_hs, rl_hs, b_hs;
      late = (c >= 500);
      if ($urandom_range(0, 19) == 0) drain = ~drain;
      slv_req.ar_valid = 1'($urandom_range(0, 1));
      slv_req.aw_valid = 1'($urandom_range(0, 1));
      mst_resp.ar_ready = ($urandom_range(0, 3) != 0);
      mst_resp.aw_ready = ($urandom_range(0, 3) != 0);
      slv_req.r_ready = ($urandom_range(0, 3) != 0);
      slv_req.b_ready = ($urandom_range(0, 3) != 0);
      mst_resp.r_valid = (m_rd > 0) ? 1'($urandom_range(0, 1)) : (late && $urandom_range(0, 9) == 0);
      mst_resp.r.last = 1'($urandom_range(0, 1));
      mst_resp.r.resp = (late && $urandom_range(0, 15) == 0) ? 2'b10 : 2'b00;
      mst_resp.b_valid = (m_wr > 0) ? 1'($urandom_range(0, 1)) : (late && $urandom_range(0, 9) == 0);
      mst_resp.b.resp = (late && $urandom_range(0, 15) == 0) ? 2'b11 : 2'b00;
      #2;
      blk_r = (m_rd == MaxR) || (m_mode != 0);
      blk_w = (m_wr == MaxW) || (m_mode != 0);
      chk("rnd_mst_ar_valid", mst_req.ar_valid, slv_req.ar_valid && !blk_r);
      chk("rnd_slv_ar_ready", slv_resp.ar_ready, mst_resp.ar_ready && !blk_r);
      chk("rnd_mst_aw_valid", mst_req.aw_valid, slv_req.aw_valid && !blk_w);
      chk("rnd_slv_aw_ready", slv_resp.aw_ready, mst_resp.aw_ready && !blk_w);
      ar_hs = slv_req.ar_valid && !blk_r && mst_resp.ar_ready;
      aw_hs = slv_req.aw_valid && !blk_w && mst_resp.aw_ready;
      r_hs  = mst_resp.r_valid && slv_req.r_ready;
      rl_hs = r_hs && mst_resp.r.last;
      b_hs  = mst_resp.b_valid && slv_req.b_ready;
      if (slv_req.ar_valid && blk_r) m_rs++;
      if (slv_req.aw_valid && blk_w) m_ws++;
      if (m_mode == 0) begin
        if (drain) m_mode = 1;
      end else if (m_mode == 1) begin
        if (!drain) m_mode = 0;
        else if (m_rd == 0 && m_wr == 0) m_mode = 2;
      end else if (!drain) begin
        m_mode = 0;
      end
      if (ar_hs && !rl_hs) m_rd++;
      else if (rl_hs && !ar_hs) begin
        if (m_rd == 0) m_err = 1;
        else m_rd--;
      end
      if (aw_hs && !b_hs) m_wr++;
      else if (b_hs && !aw_hs) begin
        if (m_wr == 0) m_err = 1;
        else m_wr--;
      end
      if (r_hs && mst_resp.r.resp[1]) m_err = 1;
      if (b_hs && mst_resp.b.resp[1]) m_err = 1;
      tick();
      chk("rnd_rd_out", rd_out, m_rd);
      chk("rnd_wr_out", wr_out, m_wr);
      chk("rnd_error", err, m_err);
      chk("rnd_drain_ack", drain_ack, m_mode == 2);
`ifdef VLSU_OT_LIMITER_STATS_EN
      chk("rnd_rd_stall", rd_stall, m_rs);
      chk("rnd_wr_stall", wr_stall, m_ws);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
